// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding, default operand width and the half-adder helper used by the
// full-adder cell.
package serial_adder_pkg;

    // Default operand / result width.
    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    // Half adder: returns {carry, sum} of two single bits.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        logic [1:0] res;
        res[0] = x ^ y;
        res[1] = x & y;
        return res;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages; the
// carry-out is the OR of the two half-adder carries (they can never both
// be set, so OR equals the majority of x, y, ci).
module serial_fa_cell
    import serial_adder_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic [1:0] ha0;
    logic [1:0] ha1;

    // First stage adds the operand bits, second stage folds in the carry.
    assign ha0 = half_add(x, y);
    assign ha1 = half_add(ha0[0], ci);

    assign s  = ha1[0];
    assign co = ha0[1] | ha1[1];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are accepted on a valid/ready
// handshake, summed LSB-first through a single full-adder cell over WIDTH
// cycles, and presented on a second valid/ready handshake.
//
// Optional build macro SERIAL_ADDER_SUB_EN adds a `sub` input (subtract
// a - b) and an `ovf` output (signed overflow of the result).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Counter width derived from WIDTH so it can index bits 0..WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_r;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_co;

    // The single shared full-adder cell works on the current LSBs.
    serial_fa_cell u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign sum = sum_r;

    // Sequencer: operand capture, bit-serial shifting, result hold and
    // both handshakes, with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        // Subtraction is a + ~b + 1; the +1 rides in as carry.
                        b_sh     <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
`else
                        b_sh     <= b;
                        carry    <= cin;
`endif
                        cnt      <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // Last bit: carry register still holds the carry
                        // into the MSB, fa_co is the carry out of it.
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        cout      <= fa_co;
`ifdef SERIAL_ADDER_SUB_EN
                        ovf       <= carry ^ fa_co;
`endif
                    end else begin
                        state     <= ST_RUN;
                    end
                end

                ST_DONE: begin
                    // Hold the result until the consumer takes it; no new
                    // operand is accepted in the handoff cycle.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state     <= ST_DONE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
